// File: rtl/cnn_mac_pkg.sv
// Shared types and constants for the MAC accumulate/requantize stage.
//   state_e    : accumulator FSM states (StAcc collects products, StOut holds a result)
//   DATA_MAX/MIN : W12_6 activation clamp limits
//   rnd_const  : round-half-up addend for a given right shift
package cnn_mac_pkg;

  localparam int unsigned PROD_W_DEF = 21;
  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned ACC_W_DEF  = 32;

  localparam int DATA_MAX = 2047;
  localparam int DATA_MIN = -2048;

  typedef enum logic [0:0] {
    StAcc = 1'b0,
    StOut = 1'b1
  } state_e;

  // Half an output LSB expressed in accumulator LSBs.
  function automatic int unsigned rnd_const(input int unsigned shift);
    return 32'd1 << (shift - 1);
  endfunction

endpackage

// File: rtl/cnn_requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic right shift, clamp to W12_6.
// Build option CNN_MAC_RELU_EN: negative results become 0 without flagging saturation.
//   sum_i  : signed accumulator value (12 fractional bits)
//   data_o : clamped signed result (6 fractional bits)
//   sat_o  : result was clamped
module cnn_requant_sat
  import cnn_mac_pkg::*;
#(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned SHIFT  = 6
) (
  input  logic signed [ACC_W-1:0]  sum_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     sat_o
);

  localparam logic signed [ACC_W-1:0]  MaxA = ACC_W'(DATA_MAX);
  localparam logic signed [ACC_W-1:0]  MinA = ACC_W'(DATA_MIN);
  localparam logic signed [DATA_W-1:0] MaxD = DATA_W'(DATA_MAX);
  localparam logic signed [DATA_W-1:0] MinD = DATA_W'(DATA_MIN);
  localparam logic signed [ACC_W-1:0]  Rnd  = ACC_W'(rnd_const(SHIFT));

  logic signed [ACC_W-1:0] r;

  assign r = (sum_i + Rnd) >>> SHIFT;

  always_comb begin
    data_o = r[DATA_W-1:0];
    sat_o  = 1'b0;
    if (r > MaxA) begin
      data_o = MaxD;
      sat_o  = 1'b1;
    end
`ifdef CNN_MAC_RELU_EN
    else if (r[ACC_W-1]) begin
      data_o = '0;
    end
`else
    else if (r < MinA) begin
      data_o = MinD;
      sat_o  = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/cnn_mac_acc_requant.sv
// Accumulates N_TAPS signed products plus a bias, then requantizes to W12_6 with
// round-half-up and saturation. One result per kernel, valid/ready on both sides.
// Build option CNN_MAC_RELU_EN (see cnn_requant_sat) fuses a ReLU before the clamp.
//   ap_clk/ap_rst_n      : clock, async active-low reset
//   in_prod/in_bias      : product stream; bias sampled with tap 0
//   in_valid/in_ready    : input handshake
//   out_data/out_sat     : requantized result and clamp flag
//   out_valid/out_ready  : output handshake
module cnn_mac_acc_requant
  import cnn_mac_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned N_TAPS = 9,
  parameter int unsigned SHIFT  = 6
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_bias,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned CntW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CntW-1:0] LastTap = CntW'(N_TAPS - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0]  prod_ext, bias_ext, sum;
  logic signed [DATA_W-1:0] rq_data;
  logic                     rq_sat, beat, last_tap;

  assign in_ready  = (state_q == StAcc) && ap_rst_n;
  assign out_valid = (state_q == StOut);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign beat     = in_valid && in_ready;
  assign last_tap = (tap_cnt_q == LastTap);

  // Bias is W12_6; align it to the product's 12 fractional bits.
  assign prod_ext = ACC_W'(in_prod);
  assign bias_ext = ACC_W'(in_bias) <<< SHIFT;
  // Tap 0 restarts from the bias, so the final sum is available on the last beat's edge.
  assign sum      = ((tap_cnt_q == '0) ? bias_ext : acc_q) + prod_ext;

  cnn_requant_sat #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .sum_i (sum),
    .data_o(rq_data),
    .sat_o (rq_sat)
  );

  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      StAcc: begin
        if (beat) begin
          acc_d     = sum;
          tap_cnt_d = last_tap ? '0 : tap_cnt_q + CntW'(1);
          if (last_tap) begin
            out_data_d = rq_data;
            out_sat_d  = rq_sat;
            state_d    = StOut;
          end
        end
      end
      StOut: begin
        if (out_ready) state_d = StAcc;
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StAcc;
      tap_cnt_q  <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_cnt_q  <= tap_cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_cnn_mac_acc_requant.sv
module tb_cnn_mac_acc_requant;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic signed [20:0] in_prod = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [11:0] in_bias = '0;
  logic signed [11:0] out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready = 1'b0;

  typedef struct {
    logic signed [11:0] data;
    logic               sat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_mac_acc_requant dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_prod  (in_prod),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bias  (in_bias),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: bias*64 + products, round half up at bit 5, shift by 6, clamp.
  function automatic exp_t model(input longint p0, input longint prest, input longint bias);
    longint s, r;
    exp_t   e;
    s = bias * 64 + p0 + 8 * prest;
    r = (s + 32) >>> 6;
    e.sat = 1'b0;
    if (r > 2047) begin
      e.data = 12'sd2047;
      e.sat  = 1'b1;
    end else if (r < 0) begin
`ifdef CNN_MAC_RELU_EN
      e.data = '0;
`else
      if (r < -2048) begin
        e.data = -12'sd2048;
        e.sat  = 1'b1;
      end else begin
        e.data = 12'(r);
      end
`endif
    end else begin
      e.data = 12'(r);
    end
    return e;
  endfunction

  task automatic send_beat(input int prod, input int bias);
    int n = 0;
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_prod  = 21'(prod);
    in_bias  = 12'(bias);
    while (!in_ready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", in_ready, 1);
    @(posedge ap_clk);
  endtask

  task automatic send_kernel(input int p0, input int prest, input int bias, input bit gaps);
    sb_q.push_back(model(p0, prest, bias));
    for (int t = 0; t < 9; t++) begin
      send_beat((t == 0) ? p0 : prest, (t == 0) ? bias : 0);
      if (gaps && t < 8) begin
        @(negedge ap_clk);
        in_valid = 1'b0;
        in_prod  = 21'sd12345;  // junk while idle must be ignored
        check("gap_tap_cnt", dut.tap_cnt_q, t + 1);
      end
    end
    @(negedge ap_clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_data"}, out_data, e.data);
      check({tag, "_sat"}, out_sat, e.sat);
      for (int i = 0; i < hold; i++) begin
        @(negedge ap_clk);
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_data"}, out_data, e.data);
        check({tag, "_hold_in_ready"}, in_ready, 0);
      end
    end
    out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_tap_cnt", dut.tap_cnt_q, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("post_rst_in_ready", in_ready, 1);

    // Basic accumulation and bias
    send_kernel(4096, 4096, 0, 1'b0);
    get_result("k576", 0);
    send_kernel(4096, 4096, 64, 1'b0);
    get_result("k640", 0);

    // Rounding boundaries
    send_kernel(32, 0, 0, 1'b0);
    get_result("rnd32", 0);
    send_kernel(31, 0, 0, 1'b0);
    get_result("rnd31", 0);
    send_kernel(-32, 0, 0, 1'b0);
    get_result("rndm32", 0);
    send_kernel(-33, 0, 0, 1'b0);
    get_result("rndm33", 0);

    // Saturation
    send_kernel(1048575, 1048575, 0, 1'b0);
    get_result("sat_pos", 0);
    send_kernel(-1048576, -1048576, 0, 1'b0);
    get_result("sat_neg", 0);

    // Backpressure, then a following kernel
    send_kernel(4096, 4096, 0, 1'b0);
    get_result("bp", 5);
    send_kernel(4096, 4096, 64, 1'b0);
    get_result("after_bp", 0);

    // in_valid gaps inside a kernel
    send_kernel(4096, 4096, 0, 1'b1);
    get_result("gaps", 0);

    // Reset mid-kernel discards partial sum
    for (int t = 0; t < 4; t++) send_beat(4096, 100);
    @(negedge ap_clk);
    in_valid = 1'b0;
    check("mid_tap_cnt", dut.tap_cnt_q, 4);
    #2 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_tap_cnt", dut.tap_cnt_q, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    send_kernel(4096, 4096, 0, 1'b0);
    get_result("post_rst", 0);

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
